// File: rtl/state_pkg.sv
// state_pkg: shared FSM state encodings for the level and player logic
package state_pkg;
    typedef enum logic {S2_WAIT, S2_RUN} State2;
    typedef enum logic [1:0] {P_IDLE, P_LEFT, P_RIGHT, P_BLOCKED} PlayerState;
endpackage

// File: rtl/draw_player_ctl_n_gate_limit.sv
// gate_limit: clips a candidate player X against every closed gate lying fully ahead
module gate_limit #(
    parameter int XW = 12,
    parameter int PLAYER_W = 40,
    parameter int NUM_GATES = 2,
    parameter logic [NUM_GATES*XW-1:0] GATE_L = {12'd550, 12'd310},
    parameter logic [NUM_GATES*XW-1:0] GATE_R = {12'd600, 12'd450}
) (
    input  logic [XW-1:0]        x_i,
    input  logic [XW:0]          cand_i,
    input  logic                 right_i,
    input  logic [NUM_GATES-1:0] gate_open_i,
    output logic [XW:0]          cand_o
);
    localparam logic [XW:0] PW = (XW+1)'(PLAYER_W);
    logic [XW:0] x_w;
    assign x_w = {1'b0, x_i};
    function automatic logic [XW:0] bound(input logic [NUM_GATES*XW-1:0] v, input int g);
        return {1'b0, v[g*XW +: XW]};
    endfunction
    // gates overlapping the player are skipped so it can always walk out
    always_comb begin
        cand_o = cand_i;
        for (int g = 0; g < NUM_GATES; g++) begin
            if (!gate_open_i[g] && right_i && bound(GATE_L, g) >= x_w + PW && cand_o > bound(GATE_L, g) - PW)
                cand_o = bound(GATE_L, g) - PW;
            if (!gate_open_i[g] && !right_i && bound(GATE_R, g) < x_w && cand_o < bound(GATE_R, g) + 1'b1)
                cand_o = bound(GATE_R, g) + 1'b1;
        end
    end
endmodule

// File: rtl/draw_player_ctl_n.sv
// draw_player_ctl_n: per-frame horizontal player motion with acceleration, screen clamp and gates
module draw_player_ctl_n
    import state_pkg::*;
#(
    parameter int XW = 12,
    parameter int X_MIN = 0,
    parameter int X_MAX = 700,
    parameter int X_START = 0,
    parameter int PLAYER_W = 40,
    parameter int NUM_GATES = 2,
    parameter logic [NUM_GATES*XW-1:0] GATE_L = {12'd550, 12'd310},
    parameter logic [NUM_GATES*XW-1:0] GATE_R = {12'd600, 12'd450},
    parameter int MAX_SPEED = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 v_tick,
    input  logic                 move_left,
    input  logic                 move_right,
    input  logic [NUM_GATES-1:0] gate_open,
    output logic [XW-1:0]        xpos_player,
    output logic [3:0]           speed,
    output logic                 blocked,
    output PlayerState           state
);
    localparam logic [XW:0] X_LO = (XW+1)'(X_MIN);
    localparam logic [XW:0] X_HI = (XW+1)'(X_MAX - PLAYER_W + 1);
    localparam logic [3:0] S_MAX = 4'(MAX_SPEED);
    logic tick_q;
    logic [XW-1:0] x_q, x_d;
    logic [3:0] speed_q, speed_d, spd;
    logic blocked_q, blocked_d;
    PlayerState state_q, state_d;
    logic frame, cmd, cont;
    logic [XW:0] x_w, step, cand_r, cand_l, cand, lim;
    assign frame = v_tick & ~tick_q;
    assign cmd = move_left ^ move_right;
    assign cont = (state_q == P_RIGHT && move_right) || (state_q == P_LEFT && move_left);
    assign spd = !cont ? 4'd1 : speed_q >= S_MAX ? S_MAX : speed_q + 4'd1;
    assign x_w = {1'b0, x_q};
    assign step = (XW+1)'(spd);
    assign cand_r = x_w + step > X_HI ? X_HI : x_w + step;
    assign cand_l = x_w < X_LO + step ? X_LO : x_w - step;
    assign cand = move_right ? cand_r : cand_l;
    gate_limit #(
        .XW(XW), .PLAYER_W(PLAYER_W), .NUM_GATES(NUM_GATES), .GATE_L(GATE_L), .GATE_R(GATE_R)
    ) u_gate_limit (
        .x_i(x_q), .cand_i(cand), .right_i(move_right), .gate_open_i(gate_open), .cand_o(lim)
    );
    always_comb begin
        x_d = x_q;
        speed_d = speed_q;
        blocked_d = blocked_q;
        state_d = state_q;
        if (frame && !cmd) begin
            state_d = P_IDLE;
            speed_d = 4'd0;
            blocked_d = 1'b0;
        end else if (frame && lim == x_w) begin
            state_d = P_BLOCKED;
            speed_d = 4'd0;
            blocked_d = 1'b1;
        end else if (frame) begin
            state_d = move_right ? P_RIGHT : P_LEFT;
            x_d = lim[XW-1:0];
            speed_d = spd;
            blocked_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= 1'b0;
            x_q <= XW'(X_START);
            speed_q <= 4'd0;
            blocked_q <= 1'b0;
            state_q <= P_IDLE;
        end else begin
            tick_q <= v_tick;
            x_q <= x_d;
            speed_q <= speed_d;
            blocked_q <= blocked_d;
            state_q <= state_d;
        end
    end
    assign xpos_player = x_q;
    assign speed = speed_q;
    assign blocked = blocked_q;
    assign state = state_q;
endmodule

// File: tb/tb_draw_player_ctl_n.sv
// tb_draw_player_ctl_n: directed scenarios plus random frames against a behavioural player model
module tb_draw_player_ctl_n;
    import state_pkg::*;
    localparam int XW = 12, W = 40, XMAX = 700, XMIN = 0, XST = 0, MAXS = 4;
    logic clk = 1'b0, rst, v_tick, move_left, move_right;
    logic [1:0] gate_open;
    logic [XW-1:0] xpos_player;
    logic [3:0] speed;
    logic blocked;
    PlayerState state;
    int n_chk = 0, n_fail = 0;
    int mx, msp, mbl;
    PlayerState ms;
    int gl[2] = '{310, 550};
    int gr[2] = '{450, 600};
    int ramp[6] = '{1, 3, 6, 10, 14, 18};

    draw_player_ctl_n dut (
        .clk(clk), .rst(rst), .v_tick(v_tick), .move_left(move_left), .move_right(move_right),
        .gate_open(gate_open), .xpos_player(xpos_player), .speed(speed), .blocked(blocked), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = XST; msp = 0; mbl = 0; ms = P_IDLE;
    endtask

    task automatic model_step();
        int sp, c;
        if (move_left == move_right) begin
            ms = P_IDLE; msp = 0; mbl = 0;
            return;
        end
        sp = ((move_right && ms == P_RIGHT) || (move_left && ms == P_LEFT)) ? (msp + 1 < MAXS ? msp + 1 : MAXS) : 1;
        if (move_right) begin
            c = mx + sp < XMAX - W + 1 ? mx + sp : XMAX - W + 1;
            for (int g = 0; g < 2; g++)
                if (!gate_open[g] && gl[g] >= mx + W && gl[g] - W < c) c = gl[g] - W;
        end else begin
            c = mx - sp > XMIN ? mx - sp : XMIN;
            for (int g = 0; g < 2; g++)
                if (!gate_open[g] && gr[g] < mx && gr[g] + 1 > c) c = gr[g] + 1;
        end
        if (c == mx) begin
            ms = P_BLOCKED; msp = 0; mbl = 1;
        end else begin
            mx = c; msp = sp; mbl = 0; ms = move_right ? P_RIGHT : P_LEFT;
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".x"}, xpos_player, mx);
        check({tag, ".speed"}, speed, msp);
        check({tag, ".blocked"}, blocked, mbl);
        check({tag, ".state"}, state, ms);
    endtask

    task automatic frame();
        @(negedge clk) v_tick = 1'b1;
        @(negedge clk) v_tick = 1'b0;
        model_step();
        check_all("frame");
    endtask

    task automatic set_cmd(logic l, logic r);
        move_left = l; move_right = r;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        #1 model_reset();
        check_all("rst");
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; v_tick = 1'b0; set_cmd(0, 0); gate_open = 2'b11;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        set_cmd(0, 1);
        for (int i = 0; i < 6; i++) begin
            frame();
            check("ramp", xpos_player, ramp[i]);
        end
        check("ramp.sat", speed, 4);

        do_reset();
        gate_open = 2'b00;
        for (int i = 0; i < 100 && !mbl; i++) frame();
        check("gate0.stop", xpos_player, 270);
        check("gate0.blocked", blocked, 1);
        check("gate0.speed", speed, 0);
        gate_open = 2'b01;
        frame();
        check("gate0.open.x", xpos_player, 271);
        check("gate0.open.speed", speed, 1);
        gate_open = 2'b11;
        for (int i = 0; i < 200 && !mbl; i++) frame();
        check("edge.x", xpos_player, 661);
        check("edge.blocked", blocked, 1);

        do_reset();
        repeat (6) frame();
        set_cmd(0, 0); frame();
        set_cmd(0, 1); repeat (3) frame();
        set_cmd(1, 0); repeat (7) frame();
        check("left.x2", xpos_player, 2);
        check("left.speed4", speed, 4);
        frame();
        check("left.min", xpos_player, 0);
        frame();
        check("left.blocked", blocked, 1);
        check("left.state", state, P_BLOCKED);

        do_reset();
        set_cmd(0, 1);
        for (int i = 0; i < 120 && mx != 330; i++) frame();
        check("reach330", xpos_player, 330);
        gate_open = 2'b10;
        set_cmd(1, 0); repeat (3) frame();
        check("inside.left", xpos_player, 324);
        gate_open = 2'b00;
        set_cmd(0, 1);
        for (int i = 0; i < 100 && !mbl; i++) frame();
        check("gate1.stop", xpos_player, 510);

        set_cmd(1, 1); frame();
        check("both.x", xpos_player, 510);
        check("both.state", state, P_IDLE);

        set_cmd(0, 1); gate_open = 2'b11;
        @(negedge clk) v_tick = 1'b1;
        @(negedge clk);
        model_step();
        check_all("hold.first");
        repeat (9) @(negedge clk);
        check_all("hold.high");
        check("hold.x", xpos_player, 511);
        v_tick = 1'b0;
        @(negedge clk);
        check_all("hold.end");

        repeat (2) frame();
        check("mid.speed3", speed, 3);
        do_reset();
        check("mid.rst.x", xpos_player, XST);
        check("mid.rst.state", state, P_IDLE);
        frame();
        check("mid.restart.speed", speed, 1);

        for (int i = 0; i < 400; i++) begin
            int r;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                {move_left, move_right} = 2'($urandom);
                gate_open = 2'($urandom);
            end
            check_all("between");
            if ($urandom_range(0, 49) == 0) do_reset();
            r = $urandom_range(0, 9);
            if (r < 4) set_cmd(0, 1);
            else if (r < 7) set_cmd(1, 0);
            else set_cmd(r[0], r[0]);
            gate_open = 2'($urandom);
            frame();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
